// File: rtl/nanocore_dbus_router.sv
// rtl/nanocore_dbus_router.sv - NanoCore data-bus router with in-order outstanding FIFO.
// Define DBUS_ROUTER_ERR_EN to answer unmapped addresses internally with an error response.
module nanocore_dbus_router #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_OUT   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req,
  input  logic                          i_we,
  input  logic [31:0]                   i_addr,
  input  logic [DATA_W/8-1:0]           i_wstrb,
  input  logic [DATA_W-1:0]             i_wdata,
  output logic                          o_gnt,
  output logic                          o_rvalid,
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_err,
  output logic [NUM_PORTS-1:0]          o_dev_req,
  output logic                          o_dev_we,
  output logic [31:0]                   o_dev_addr,
  output logic [DATA_W/8-1:0]           o_dev_wstrb,
  output logic [DATA_W-1:0]             o_dev_wdata,
  input  logic [NUM_PORTS-1:0]          i_dev_gnt,
  input  logic [NUM_PORTS-1:0]          i_dev_rvalid,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_dev_rdata,
  output logic [$clog2(MAX_OUT+1)-1:0]  o_outstanding,
  output logic                          o_proto_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int PTR_W  = $clog2(MAX_OUT);
  localparam logic [3:0] TAG_ERR = 4'hF;

  logic [3:0]       sel;
  logic             mapped;
  logic [3:0]       route;
  logic             to_slave;
  logic             full;
  logic             empty;
  logic             req_ok;
  logic             slave_gnt;
  logic [3:0]       push_tag;
  logic             push;
  logic             pop;
  logic             proto_hit;
  logic [3:0]       head;

  logic [3:0]       fifo_q [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             proto_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  assign sel    = i_addr[31:28];
  assign mapped = ({1'b0, sel} < 5'(NUM_PORTS));

`ifdef DBUS_ROUTER_ERR_EN
  assign route    = sel;
  assign to_slave = mapped;
`else
  localparam logic [3:0] LAST_PORT = 4'(NUM_PORTS - 1);
  assign route    = mapped ? sel : LAST_PORT;
  assign to_slave = 1'b1;
`endif

  assign full   = (count_q == CNT_W'(MAX_OUT));
  assign empty  = (count_q == '0);
  // A full FIFO blocks new requests even when the head retires this cycle.
  assign req_ok = i_req & ~full & ~i_rst;

  always_comb begin
    o_dev_req = '0;
    slave_gnt = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (to_slave && (route == 4'(k))) begin
        o_dev_req[k] = req_ok;
        slave_gnt    = i_dev_gnt[k];
      end
    end
  end

  assign o_gnt    = to_slave ? (req_ok & slave_gnt) : req_ok;
  assign push     = o_gnt;
  assign push_tag = to_slave ? route : TAG_ERR;

  assign o_dev_we    = (i_req & ~i_rst) ? i_we    : we_q;
  assign o_dev_addr  = (i_req & ~i_rst) ? i_addr  : addr_q;
  assign o_dev_wstrb = (i_req & ~i_rst) ? i_wstrb : wstrb_q;
  assign o_dev_wdata = (i_req & ~i_rst) ? i_wdata : wdata_q;

  assign head = fifo_q[rd_ptr_q];

`ifdef DBUS_ROUTER_ERR_EN
  logic err_rsp;
  assign err_rsp = ~empty & (head == TAG_ERR);
  assign o_err   = err_rsp;
`else
  assign o_err   = 1'b0;
`endif

  // Only the slave at the FIFO head may answer; anything else is dropped and flagged.
  always_comb begin
    o_rvalid  = 1'b0;
    o_rdata   = '0;
    proto_hit = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (i_dev_rvalid[k]) begin
        if (!empty && (head == 4'(k))) begin
          o_rvalid = 1'b1;
          o_rdata  = i_dev_rdata[k*DATA_W +: DATA_W];
        end else begin
          proto_hit = 1'b1;
        end
      end
    end
`ifdef DBUS_ROUTER_ERR_EN
    if (err_rsp) begin
      o_rvalid = 1'b1;
      o_rdata  = '0;
    end
`endif
  end

  assign pop = o_rvalid;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      proto_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_tag;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        we_q             <= i_we;
        addr_q           <= i_addr;
        wstrb_q          <= i_wstrb;
        wdata_q          <= i_wdata;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      proto_q <= proto_q | proto_hit;
    end
  end

  assign o_outstanding = count_q;
  assign o_proto_err   = proto_q;

endmodule

// File: doc/nanocore_dbus_router.md
# nanocore_dbus_router

Parametrised data-bus router between the NanoCore data port and NUM_PORTS downstream slaves: one memory slave plus peripheral slaves. It decodes each core request by address nibble, forwards it to exactly one slave, and records the target in an in-order outstanding-transaction FIFO. Returned responses are steered back to the core from the slave at the FIFO head. Unmapped addresses are either answered internally with an error or routed to a default slave. It replaces the fixed memory/peripheral split in the core wrapper.

## Interface
Parameters:
- NUM_PORTS, 4: number of downstream slaves (2..15); port 0 is memory.
- DATA_W, 32: data width; wstrb width is DATA_W/8.
- MAX_OUT, 4: outstanding-transaction capacity (power of two, 2..16).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_req  in  1  core request
- i_we  in  1  1 = write, 0 = read
- i_addr  in  32  byte address
- i_wstrb  in  DATA_W/8  write strobes
- i_wdata  in  DATA_W  write data
- o_gnt  out  1  request accepted this cycle
- o_rvalid  out  1  response valid to core
- o_rdata  out  DATA_W  response data
- o_err  out  1  response is a decode error (qualified by o_rvalid)
- o_dev_req  out  NUM_PORTS  one-hot per-slave request
- o_dev_we, o_dev_addr, o_dev_wstrb, o_dev_wdata  out  1/32/DATA_W/8/DATA_W  shared request payload
- i_dev_gnt  in  NUM_PORTS  per-slave grant
- i_dev_rvalid  in  NUM_PORTS  per-slave response valid
- i_dev_rdata  in  NUM_PORTS*DATA_W  per-slave response data, slave k at [k*DATA_W +: DATA_W]
- o_outstanding  out  $clog2(MAX_OUT+1)  current FIFO occupancy
- o_proto_err  out  1  sticky: response arrived from a non-head slave

## Operation
- Decode: sel = i_addr[31:28]. sel < NUM_PORTS selects slave sel; otherwise the request is unmapped.
- Mapped request: o_dev_req[sel] = i_req & ~full. o_gnt = i_dev_gnt[sel] & i_req & ~full. On o_gnt, push sel into the FIFO.
- Unmapped request (ERR build): o_dev_req stays all zero. o_gnt = i_req & ~full. On o_gnt, push the ERR tag (value 15).
- Payload: o_dev_addr/we/wstrb/wdata equal the live inputs while i_req=1. When i_req=0, they hold the last granted values in hold registers.
- Every granted transaction, read or write, receives exactly one response.
- Response from a slave: when the FIFO is non-empty with head h < NUM_PORTS, o_rvalid = i_dev_rvalid[h], o_rdata = slave h data, and o_err = 0. The FIFO pops on o_rvalid.
- Response for an ERR head: o_rvalid = 1, o_rdata = 0, o_err = 1, and the FIFO pops the same cycle.
- Protocol violation: if i_dev_rvalid[k]=1 with k not equal to the head, or with the FIFO empty, the response is dropped and o_proto_err sets. Only reset clears o_proto_err.
- Full: while occupancy == MAX_OUT, o_gnt = 0 and o_dev_req = 0, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: occupancy is unchanged and both operations take effect.
- Pointers wrap modulo MAX_OUT.

## Timing
- The request path and response steering are combinational (zero latency). FIFO, counter, hold registers and sticky flag update on the rising edge of i_clk.
- A transaction granted in cycle N can be answered no earlier than cycle N+1. An ERR response appears in the first cycle its tag is at the head, which is N+1 at the earliest.
- Reset (asynchronous, active-high, any time, including with transactions in flight):
  - FIFO is emptied; o_outstanding = 0.
  - o_gnt = 0, o_rvalid = 0, o_err = 0, o_dev_req = 0, o_proto_err = 0.
  - Hold registers and o_rdata = 0.
  - In-flight responses arriving after reset count as protocol errors.

## Configuration
- Macro DBUS_ROUTER_ERR_EN.
- Defined: unmapped addresses get an internal error response, as described above.
- Undefined: unmapped addresses route to slave NUM_PORTS-1. The ERR tag is never pushed, and o_err is tied to 0.

## Test plan
- Read to 0x0000_0100 with i_dev_gnt[0]=1, slave 0 returning 0xDEAD_BEEF one cycle later -> o_gnt=1 in cycle 0; o_rvalid=1 and o_rdata=0xDEAD_BEEF in cycle 1; o_outstanding returns to 0.
- Four back-to-back reads to slaves 1, 2, 1, 3 with all grants high and no responses -> o_outstanding=4 and a fifth request sees o_gnt=0. Then an early i_dev_rvalid[2] sets o_proto_err; in-order responses 1, 2, 1, 3 drain the FIFO to 0.
- Read to 0xF000_0000 with ERR enabled -> o_gnt=1; next cycle o_rvalid=1, o_err=1, o_rdata=0. With ERR disabled -> o_dev_req[3]=1.
- Write to 0x2000_0004 with i_dev_gnt[2]=0 for 3 cycles -> o_dev_req[2] is held high, o_gnt=0; o_gnt=1 in cycle 3; after i_req drops, o_dev_addr stays 0x2000_0004.
- FIFO at occupancy 2 with simultaneous grant and head response -> occupancy stays 2. Wrap test: 10 sequential transactions with MAX_OUT=4 all complete in order.
- i_rst asserted with 3 transactions outstanding -> all outputs 0 immediately; a subsequent stray i_dev_rvalid[1] sets o_proto_err.
